// File: rtl/crc5_check_unfold3.sv
// Receive-side CRC-5 checker, g(y) = 1 + y + y^3 + y^5.
// Three serial division steps per accepted beat; one result per frame.
module crc5_check_unfold3 #(
    parameter int MSG_BITS = 10,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_data,
    input  logic             in_abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       syndrome,
    output logic             crc_ok,
    output logic             busy,
    output logic [CNT_W-1:0] err_count
);

    localparam int BEATS = (MSG_BITS + 5) / 3;
    localparam int BW    = $clog2(BEATS + 1);

    if ((MSG_BITS + 5) % 3 != 0) begin : g_bad_msg_bits
        $error("crc5_check_unfold3: MSG_BITS+5 must be a multiple of 3");
    end

    typedef enum logic {
        RECV,
        RESULT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [4:0]    lfsr;
    logic [BW-1:0] beat_cnt;
    logic [4:0]    lfsr_step;
    logic          take;
    logic          last;

    function automatic logic [4:0] step1(input logic [4:0] r, input logic b);
        return {r[3:0], b} ^ (r[4] ? 5'b01011 : 5'b00000);
    endfunction

    // in_data[2] is earliest on the wire, so it is divided in first
    function automatic logic [4:0] step3(input logic [4:0] r, input logic [2:0] d);
        logic [4:0] t;
        t = step1(r, d[2]);
        t = step1(t, d[1]);
        t = step1(t, d[0]);
        return t;
    endfunction

    assign lfsr_step = step3(lfsr, in_data);
    assign take      = (state == RECV) && in_valid && !in_abort;
    assign last      = (beat_cnt == BW'(BEATS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RECV;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            RECV: begin
                in_ready = 1'b1;
                busy     = (beat_cnt != '0);
                if (take && last) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = RECV;
                end
            end
            default: state_next = RECV;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr      <= '0;
            beat_cnt  <= '0;
            syndrome  <= '0;
            crc_ok    <= 1'b0;
            err_count <= '0;
        end else if (state == RECV) begin
            if (in_abort) begin
                lfsr     <= '0;
                beat_cnt <= '0;
            end else if (in_valid) begin
                if (last) begin
                    lfsr     <= '0;
                    beat_cnt <= '0;
                    syndrome <= lfsr_step;
                    crc_ok   <= (lfsr_step == 5'd0);
                    if ((lfsr_step != 5'd0) && (err_count != '1)) begin
                        err_count <= err_count + 1'b1;
                    end
                end else begin
                    lfsr     <= lfsr_step;
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc5_check_unfold3.sv
// Bench for crc5_check_unfold3: directed scenarios plus random frames,
// checked every cycle against a polynomial-division frame model.
module tb_crc5_check_unfold3;

    localparam int NB = 15;
    localparam logic [14:0] F1 = 15'b100_000_000_010_101;
    localparam logic [14:0] F2 = 15'b100_000_000_010_100;
    localparam logic [14:0] F3 = 15'b000_000_000_010_101;
    localparam logic [14:0] F4 = 15'b000_000_000_101_011;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_abort = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] in_data = 3'd0;

    logic       in_ready, out_valid, crc_ok, busy;
    logic [4:0] syndrome;
    logic [7:0] err_count;
    logic       in_ready2, out_valid2, crc_ok2, busy2;
    logic [4:0] syndrome2;
    logic [1:0] err_count2;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    crc5_check_unfold3 #(.MSG_BITS(10), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_abort(in_abort), .out_valid(out_valid),
        .out_ready(out_ready), .syndrome(syndrome), .crc_ok(crc_ok),
        .busy(busy), .err_count(err_count)
    );

    crc5_check_unfold3 #(.MSG_BITS(10), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_abort(in_abort), .out_valid(out_valid2),
        .out_ready(out_ready), .syndrome(syndrome2), .crc_ok(crc_ok2),
        .busy(busy2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // codeword mod g by plain long division
    function automatic logic [4:0] polymod(input logic [14:0] cw);
        logic [14:0] r;
        r = cw;
        for (int i = 14; i >= 5; i--) begin
            if (r[i]) r = r ^ (15'b101011 << (i - 5));
        end
        return r[4:0];
    endfunction

    // frame-level model: collected bits, pending result, error totals
    bit         mq[$];
    bit         m_pend = 1'b0;
    logic [4:0] m_syn = 5'd0;
    bit         m_ok = 1'b0;
    int         m_err = 0;
    int         m_err2 = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_pend = 1'b0;
            m_err = 0;
            m_err2 = 0;
        end else if (m_pend) begin
            if (out_ready) m_pend = 1'b0;
        end else if (in_abort) begin
            mq.delete();
        end else if (in_valid) begin
            for (int i = 2; i >= 0; i--) mq.push_back(in_data[i]);
            if (mq.size() == NB) begin
                logic [14:0] cw;
                for (int i = 0; i < NB; i++) cw[14-i] = mq[i];
                m_syn = polymod(cw);
                m_ok = (m_syn == 5'd0);
                m_pend = 1'b1;
                if (!m_ok) begin
                    if (m_err < 255) m_err++;
                    if (m_err2 < 3) m_err2++;
                end
                mq.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready", in_ready, !m_pend);
            chk("out_valid", out_valid, m_pend);
            chk("busy", busy, !m_pend && mq.size() != 0);
            chk("err_count", err_count, m_err);
            chk("err_count2", err_count2, m_err2);
            chk("out_valid2", out_valid2, m_pend);
            chk("in_ready2", in_ready2, !m_pend);
            chk("busy2", busy2, !m_pend && mq.size() != 0);
            if (m_pend) begin
                chk("syndrome", syndrome, m_syn);
                chk("crc_ok", crc_ok, m_ok);
                chk("syndrome2", syndrome2, m_syn);
                chk("crc_ok2", crc_ok2, m_ok);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] d);
        in_valid = 1'b1;
        in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [14:0] cw, input bit gaps);
        for (int k = 0; k < 5; k++) begin
            beat(cw[14-3*k -: 3]);
            if (gaps && k < 4) tick();
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_in_ready"}, in_ready, 1);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_syndrome"}, syndrome, 0);
        chk({nm, "_crc_ok"}, crc_ok, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_err"}, err_count, 0);
    endtask

    initial begin
        int exp2[5];
        exp2 = '{1, 2, 3, 3, 3};

        chk("pin_f1", polymod(F1), 5'b00000);
        chk("pin_f2", polymod(F2), 5'b00001);
        chk("pin_f3", polymod(F3), 5'b10101);
        chk("pin_f4", polymod(F4), 5'b00000);

        #1 reset = 1'b1;
        chk_on = 1'b1;
        tick();
        chk_reset_outputs("reset");
        tick();
        reset = 1'b0;
        tick();

        out_ready = 1'b1;
        send_frame(F1, 1'b0);
        chk("s1_valid", out_valid, 1);
        chk("s1_syn", syndrome, 5'b00000);
        chk("s1_ok", crc_ok, 1);
        chk("s1_err", err_count, 0);
        tick();

        send_frame(F2, 1'b0);
        chk("s2a_syn", syndrome, 5'b00001);
        chk("s2a_ok", crc_ok, 0);
        chk("s2a_err", err_count, 1);
        tick();
        send_frame(F3, 1'b0);
        chk("s2b_syn", syndrome, 5'b10101);
        chk("s2b_err", err_count, 2);
        tick();

        out_ready = 1'b0;
        send_frame(F4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("s3_hold_ready", in_ready, 0);
            chk("s3_hold_valid", out_valid, 1);
            chk("s3_hold_syn", syndrome, 5'b00000);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("s3_ready_back", in_ready, 1);
        chk("s3_valid_gone", out_valid, 0);

        beat(3'b101);
        beat(3'b011);
        chk("s4_busy", busy, 1);
        in_valid = 1'b1;
        in_abort = 1'b1;
        in_data = 3'b111;
        tick();
        in_valid = 1'b0;
        in_abort = 1'b0;
        chk("s4_busy_clr", busy, 0);
        chk("s4_no_result", out_valid, 0);
        send_frame(F1, 1'b0);
        chk("s4_valid", out_valid, 1);
        chk("s4_syn", syndrome, 5'b00000);
        tick();
        chk("s4_single", out_valid, 0);

        for (int k = 0; k < 3; k++) beat(F2[14-3*k -: 3]);
        reset = 1'b1;
        #1;
        chk_reset_outputs("s5a");
        tick();
        reset = 1'b0;
        tick();
        out_ready = 1'b0;
        send_frame(F2, 1'b0);
        chk("s5_pending", out_valid, 1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("s5b");
        tick();
        reset = 1'b0;
        tick();
        out_ready = 1'b1;
        send_frame(F1, 1'b0);
        chk("s5_clean_ok", crc_ok, 1);
        tick();

        for (int i = 0; i < 5; i++) begin
            send_frame(F2, 1'b0);
            chk("s6_err2", err_count2, exp2[i]);
            chk("s6_err8", err_count, i + 1);
            tick();
        end

        for (int f = 0; f < 300; f++) begin
            logic [14:0] cw;
            int k;
            int n;
            if ($urandom % 2 == 0) begin
                logic [9:0] msg;
                msg = 10'($urandom);
                cw = {msg, polymod({msg, 5'b00000})};
            end else begin
                cw = 15'($urandom);
            end
            k = 0;
            n = 0;
            while (k < 5 && n < 200) begin
                bit acc;
                bit ab;
                in_valid = ($urandom % 4) != 0;
                in_abort = ($urandom % 40) == 0;
                in_data = cw[14-3*k -: 3];
                out_ready = ($urandom % 3) != 0;
                acc = in_valid && !m_pend && !in_abort;
                ab = in_abort && !m_pend;
                tick();
                n++;
                if (ab) k = 0;
                else if (acc) k++;
            end
            if (k < 5) chk("rand_frame_timeout", k, 5);
            in_valid = 1'b0;
            in_abort = 1'b0;
        end
        begin
            int n;
            n = 0;
            while (m_pend && n < 50) begin
                out_ready = ($urandom % 2) != 0;
                tick();
                n++;
            end
            if (m_pend) chk("drain_timeout", out_valid, 0);
        end
        out_ready = 1'b0;
        tick();
        tick();
        chk_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/crc5_check_unfold3.md
Name: crc5_check_unfold3

Overview:
Receive-side checker for the CRC-5 generator g(y) = 1 + y + y^3 + y^5, using the same 3-level unfolding as the team's transmit-side encoder.
- Accepts a serial codeword, 3 bits per clock: MSG_BITS message bits followed by 5 check bits, MSB first.
- Divides the whole codeword by g and reports the 5-bit syndrome and a pass/fail flag per frame.
- Keeps a saturating count of failed frames.
- Sits between the link deserialiser and the downstream consumer, which acknowledges each result.

Parameters:
MSG_BITS, 10, message bits per frame. (MSG_BITS+5) must be a multiple of 3; otherwise elaboration fails via a generate-time check.
CNT_W, 8, width of the failed-frame counter.
BEATS, (MSG_BITS+5)/3, derived localparam; do not override. Equals 5 at the default.

Ports:
clk  input  1  rising-edge clock, the only clock.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  in_data carries a beat.
in_ready  output  1  checker accepts a beat this cycle.
in_data  input  3  codeword bits; in_data[2] is earliest in time, in_data[0] latest.
in_abort  input  1  discard the partial frame.
out_valid  output  1  result held on syndrome/crc_ok.
out_ready  input  1  consumer accepts the result.
syndrome  output  5  codeword mod g; bit 4 is the y^4 coefficient.
crc_ok  output  1  1 when syndrome == 0.
busy  output  1  at least one beat of the current frame has been accepted.
err_count  output  CNT_W  saturating count of frames with crc_ok = 0.

Behaviour:
- Reset (async, active-high) forces: state RECV; lfsr 0; beat_cnt 0; in_ready 1; out_valid 0; syndrome 0; crc_ok 0; busy 0; err_count 0. This holds even if reset arrives mid-frame or while a result is pending; no result is emitted for a partial frame.
- Serial step, per bit b: r' = {r[3:0], b} ^ (r[4] ? 5'b01011 : 5'b00000).
  - This is augmented-form division, so the final r equals codeword mod g exactly.
  - The lfsr starts at 0; there is no xorout and no bit reflection.
- Unfolding: each accepted beat applies 3 serial steps in one cycle, in the order in_data[2], then [1], then [0]. Implement this as one combinational 3-step function of (r, in_data). There is no multicycle path.
- State RECV:
  - in_ready = 1.
  - On in_valid & in_ready & !in_abort: r <= step3(r, in_data); beat_cnt increments.
  - When the accepted beat is beat BEATS-1: register syndrome <= step3 result and crc_ok <= (step3 result == 0). Then clear r and beat_cnt and go to RESULT. out_valid rises on the same edge, so latency from the last beat to out_valid is 1 cycle.
  - err_count increments on that edge when the result is nonzero, saturating at all-ones.
- State RESULT:
  - in_ready = 0 and out_valid = 1.
  - syndrome and crc_ok stay stable until out_valid & out_ready. On that edge, return to RECV; out_valid drops next cycle and in_ready returns.
  - syndrome and crc_ok keep their last values after handoff; they are only meaningful while out_valid = 1.
  - If out_ready is already high on the first RESULT cycle, the result is held for exactly 1 cycle.
- in_abort, in RECV:
  - Clears r and beat_cnt. Any beat presented in the same cycle is dropped.
  - No result is produced and err_count is unchanged.
  - An abort when beat_cnt = 0 is a no-op. In RESULT, in_abort is ignored.
- busy = (beat_cnt != 0) while in RECV; busy = 0 in RESULT.
- in_valid = 0 cycles inside a frame are legal gaps; state and lfsr hold.

Test Plan:
1. Beats 100,000,000,010,101 (message 1000000000, CRC 10101), with out_ready held 1 -> one cycle after beat 5: out_valid = 1, syndrome = 00000, crc_ok = 1. err_count stays 0.
2. Beats 100,000,000,010,100 (last bit flipped) -> syndrome = 00001, crc_ok = 0, err_count = 1. Then beats 000,000,000,010,101 (first bit flipped) -> syndrome = 10101, err_count = 2.
3. Beats 000,000,000,101,011 (message 0000000001, CRC 01011) with in_valid gaps between beats and out_ready low for 4 cycles -> in_ready = 0 and syndrome = 00000 held stable for 4 cycles. Handoff occurs on the first cycle out_ready = 1; in_ready returns the next cycle.
4. Send 2 beats, then in_abort = 1 together with a valid beat, then the frame from scenario 1 -> the aborted partial frame emits no result. Exactly one result follows: syndrome = 00000. busy reads 1, then 0 after the abort.
5. Assert reset after beat 3 of the frame from scenario 2, and separately while out_valid = 1 -> all outputs return to their reset values and err_count = 0. A following clean frame gives crc_ok = 1.
6. With CNT_W = 2, send 5 failing frames back-to-back -> err_count reads 1, 2, 3, 3, 3.
